// File: rtl/pll_lock_sequencer_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, default timing
// constants and the saturating event-counter helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_PLLRST = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_VIDEO  = 3'd3,
    S_RUN    = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 65535;
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_STAGE_GAP      = 64;
  localparam int unsigned DEF_CNT_W          = 20;

  // Event counter that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into the clk domain.
// Output lags the input by two clk edges; both flops clear on synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, releases the
// video then core resets, and generates the /4 and /8 clock enables.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned STAGE_GAP      = DEF_STAGE_GAP,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       req_relock,
  output logic       pll_rst,
  output logic       video_rst_n,
  output logic       core_rst_n,
  output logic       ce_pix,
  output logic       ce_half,
  output logic [2:0] seq_state,
  output logic [7:0] relock_count
);

  localparam logic [CNT_W-1:0] LIM_RST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_TO     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LIM_STABLE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM_GAP    = CNT_W'(STAGE_GAP - 1);

  logic             locked_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rc_q, rc_d;
  logic [2:0]       div_q, div_d;
  logic             video_d;
  logic             pll_rst_q, video_q, core_q, ce_pix_q, ce_half_q;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (locked_s)
  );

  // Lock loss is tested before req_relock so that a coincident request still counts.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    case (state_q)
      S_PLLRST: begin
        if (cnt_q == LIM_RST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == LIM_TO) begin
          state_d = S_PLLRST;
          rc_d    = sat_inc8(rc_q);
        end
      end
      S_STABLE: begin
        if (!locked_s)                state_d = S_WAIT;
        else if (cnt_q == LIM_STABLE) state_d = S_VIDEO;
      end
      S_VIDEO, S_RUN: begin
        if (!locked_s) begin
          state_d = S_PLLRST;
          rc_d    = sat_inc8(rc_q);
        end else if (req_relock) begin
          state_d = S_PLLRST;
        end else if (state_q == S_VIDEO && cnt_q == LIM_GAP) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_PLLRST;
    endcase
  end

  assign cnt_d   = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  assign video_d = (state_d == S_VIDEO) || (state_d == S_RUN);

  // div_cnt stays 0 on the first released cycle so the first ce_pix lands in the 4th.
  assign div_d = (video_d && video_q) ? div_q + 3'd1 : 3'd0;

  // Outputs are registered from next-state values so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_PLLRST;
      cnt_q     <= '0;
      rc_q      <= 8'd0;
      div_q     <= 3'd0;
      pll_rst_q <= 1'b1;
      video_q   <= 1'b0;
      core_q    <= 1'b0;
      ce_pix_q  <= 1'b0;
      ce_half_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rc_q      <= rc_d;
      div_q     <= div_d;
      pll_rst_q <= (state_d == S_PLLRST);
      video_q   <= video_d;
      core_q    <= (state_d == S_RUN);
      ce_pix_q  <= video_d & (div_d[1:0] == 2'b11);
      ce_half_q <= video_d & (div_d == 3'b111);
    end
  end

  assign pll_rst      = pll_rst_q;
  assign video_rst_n  = video_q;
  assign core_rst_n   = core_q;
  assign ce_pix       = ce_pix_q;
  assign ce_half      = ce_half_q;
  assign seq_state    = state_q;
  assign relock_count = rc_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with shortened timing parameters:
// a per-cycle vector table for bring-up plus hand sequences for the corner cases.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       req_relock = 1'b0;
  logic       pll_rst, video_rst_n, core_rst_n, ce_pix, ce_half;
  logic [2:0] seq_state;
  logic [7:0] relock_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (32),
    .STABLE_CYCLES  (8),
    .STAGE_GAP      (4),
    .CNT_W          (20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .req_relock   (req_relock),
    .pll_rst      (pll_rst),
    .video_rst_n  (video_rst_n),
    .core_rst_n   (core_rst_n),
    .ce_pix       (ce_pix),
    .ce_half      (ce_half),
    .seq_state    (seq_state),
    .relock_count (relock_count)
  );

  typedef struct {
    logic       rst_n;
    logic       lk;
    logic       rq;
    logic [2:0] st;
    logic       pll;
    logic       vid;
    logic       core;
    logic       cp;
    logic       ch;
    logic [7:0] rc;
  } vec_t;

  vec_t vecs[$];

  task automatic push(int n, logic r, logic lk, logic rq, logic [2:0] st, logic pll,
                      logic vid, logic core, logic cp, logic ch, logic [7:0] rc);
    vec_t v;
    v.rst_n = r; v.lk = lk; v.rq = rq; v.st = st; v.pll = pll;
    v.vid = vid; v.core = core; v.cp = cp; v.ch = ch; v.rc = rc;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(logic [2:0] st, int bound, string name);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (seq_state != st && k < bound);
    check({name, " reached"}, int'(seq_state), int'(st));
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, " state"},   int'(seq_state),    0);
    check({tag, " pll_rst"}, int'(pll_rst),      1);
    check({tag, " video"},   int'(video_rst_n),  0);
    check({tag, " core"},    int'(core_rst_n),   0);
    check({tag, " ce_pix"},  int'(ce_pix),       0);
    check({tag, " ce_half"}, int'(ce_half),      0);
    check({tag, " relock"},  int'(relock_count), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rc;

    // Bring-up: reset, 4-cycle pll_rst, 10 cycles unlocked, then lock and release.
    push(2,  0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 8'd0);
    push(3,  1, 0, 0, 3'd0, 1, 0, 0, 0, 0, 8'd0);
    push(10, 1, 0, 0, 3'd1, 0, 0, 0, 0, 0, 8'd0);
    push(2,  1, 1, 0, 3'd1, 0, 0, 0, 0, 0, 8'd0);
    push(8,  1, 1, 0, 3'd2, 0, 0, 0, 0, 0, 8'd0);
    push(3,  1, 1, 0, 3'd3, 0, 1, 0, 0, 0, 8'd0);
    push(1,  1, 1, 0, 3'd3, 0, 1, 0, 1, 0, 8'd0);
    for (int d = 4; d < 16; d++)
      push(1, 1, 1, 0, 3'd4, 0, 1, 1, logic'(d % 4 == 3), logic'(d % 8 == 7), 8'd0);

    foreach (vecs[i]) begin
      rst_n      = vecs[i].rst_n;
      pll_locked = vecs[i].lk;
      req_relock = vecs[i].rq;
      tick();
      check($sformatf("vec%0d state", i),   int'(seq_state),    int'(vecs[i].st));
      check($sformatf("vec%0d pll_rst", i), int'(pll_rst),      int'(vecs[i].pll));
      check($sformatf("vec%0d video", i),   int'(video_rst_n),  int'(vecs[i].vid));
      check($sformatf("vec%0d core", i),    int'(core_rst_n),   int'(vecs[i].core));
      check($sformatf("vec%0d ce_pix", i),  int'(ce_pix),       int'(vecs[i].cp));
      check($sformatf("vec%0d ce_half", i), int'(ce_half),      int'(vecs[i].ch));
      check($sformatf("vec%0d relock", i),  int'(relock_count), int'(vecs[i].rc));
    end

    // Lock loss in S_RUN: two synchronizer edges, then the third edge resets.
    pll_locked = 1'b0;
    tick();
    tick();
    check("loss still run", int'(seq_state), 4);
    tick();
    check("loss state",   int'(seq_state),    0);
    check("loss pll_rst", int'(pll_rst),      1);
    check("loss video",   int'(video_rst_n),  0);
    check("loss core",    int'(core_rst_n),   0);
    check("loss ce_pix",  int'(ce_pix),       0);
    check("loss ce_half", int'(ce_half),      0);
    check("loss relock",  int'(relock_count), 1);

    // Re-reset, then hold unlocked: pll_rst re-pulses every 36 cycles.
    rst_n = 1'b0;
    tick();
    check_reset_vals("rst1");
    rst_n = 1'b1;
    for (int t = 1; t <= 110; t++) begin
      tick();
      check($sformatf("to t%0d pll_rst", t), int'(pll_rst), int'((t % 36) < 4));
      check($sformatf("to t%0d relock", t),  int'(relock_count), t / 36);
    end

    // One-cycle lock glitch midway through S_STABLE.
    pll_locked = 1'b1;
    wait_state(3'd2, 50, "glitch stable");
    tick(); tick(); tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    check("glitch g2 state", int'(seq_state), 2);
    tick();
    check("glitch g3 state",  int'(seq_state),    1);
    check("glitch g3 relock", int'(relock_count), 3);
    tick();
    check("glitch g4 state", int'(seq_state), 2);
    for (int k = 0; k < 7; k++) tick();
    check("glitch g11 state", int'(seq_state),   2);
    check("glitch g11 video", int'(video_rst_n), 0);
    tick();
    check("glitch g12 state", int'(seq_state),   3);
    check("glitch g12 video", int'(video_rst_n), 1);

    // req_relock alone in S_RUN: back to S_PLLRST with no increment.
    wait_state(3'd4, 20, "run1");
    req_relock = 1'b1;
    tick();
    req_relock = 1'b0;
    check("req state",  int'(seq_state),    0);
    check("req relock", int'(relock_count), 3);

    // req_relock in S_STABLE is ignored.
    wait_state(3'd2, 20, "stable2");
    req_relock = 1'b1;
    tick();
    req_relock = 1'b0;
    check("req ign state", int'(seq_state), 2);

    // Lock loss and req_relock seen in the same cycle: exactly one increment.
    wait_state(3'd4, 30, "run2");
    pll_locked = 1'b0;
    tick();
    tick();
    req_relock = 1'b1;
    tick();
    req_relock = 1'b0;
    check("both state",  int'(seq_state),    0);
    check("both relock", int'(relock_count), 4);
    tick();
    check("both relock hold", int'(relock_count), 4);

    // Repeated lock losses in S_VIDEO drive relock_count to saturation.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      wait_state(3'd3, 60, "sat video");
      pll_locked = 1'b0;
      wait_state(3'd0, 10, "sat pllrst");
      exp_rc = (5 + i > 255) ? 255 : 5 + i;
      check($sformatf("sat%0d relock", i), int'(relock_count), exp_rc);
    end

    // Reset asserted during S_VIDEO restores every reset value.
    pll_locked = 1'b1;
    wait_state(3'd3, 60, "final video");
    check("final relock", int'(relock_count), 255);
    rst_n = 1'b0;
    tick();
    check_reset_vals("rst2");
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
